// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared state encoding and nibble width for the serial adder
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit4_parallel_adder.sv
// rtl/bit4_parallel_adder.sv - combinational 4-bit adder with carry in/out
module bit4_parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that reuses one 4-bit adder over WIDTH/4 cycles
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_carry;
  logic [WIDTH-1:0] sum_nx;
  logic             last;

  bit4_parallel_adder u_nib (
    .a     (a_sh[NIB_W-1:0]),
    .b     (b_sh[NIB_W-1:0]),
    .cin   (carry_reg),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  assign last = (cnt == CNT_W'(NIB - 1));

  // Partial sums enter from the top; after NIB passes nibble 0 has reached bit 0.
  // Only the upper WIDTH-4 bits need storing, since the newest nibble comes straight from the adder.
  generate
    if (NIB == 1) begin : g_single
      assign sum_nx = nib_sum;
    end else begin : g_multi
      logic [WIDTH-NIB_W-1:0] sum_sh;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_sh <= '0;
        end else if (state == S_RUN) begin
          sum_sh <= sum_nx[WIDTH-1:NIB_W];
        end
      end

      assign sum_nx = {nib_sum, sum_sh};
    end
  endgenerate

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nx = S_RUN;
      S_RUN:   if (last)      state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            cnt       <= '0;
          end
        end
        S_RUN: begin
          a_sh      <= a_sh >> NIB_W;
          b_sh      <= b_sh >> NIB_W;
          carry_reg <= nib_carry;
          cnt       <= cnt + CNT_W'(1);
          // The result registers load only here, so consumers never see partial sums.
          if (last) begin
            sum_q   <= sum_nx;
            carry_q <= nib_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign sum       = sum_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized and directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, busy;
  logic [W-1:0] sum;

  logic       iv4 = 1'b0, ordy4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, carry4, busy4;
  logic [3:0] sum4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry(carry), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(ordy4),
    .sum(sum4), .carry(carry4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a request becomes a result N cycles after acceptance, held until taken.
  int         m_run = 0;
  bit         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic       m_carry = 1'b0;
  logic [W:0] m_pend = '0;
  int         m_acc = 0;
  int         dut_hs = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_done = 1'b0; m_sum = '0; m_carry = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_run > 0) begin
      m_run--;
      if (m_run == 0) begin
        m_done = 1'b1;
        {m_carry, m_sum} = m_pend;
      end
    end else if (in_valid) begin
      m_run  = N;
      m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      m_acc++;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cycle_outputs", {44'd0, in_ready, out_valid, busy, carry, sum},
        {44'd0, (!m_done && m_run == 0), m_done, (m_done || m_run != 0), m_carry, m_sum});
    if (out_valid && out_ready) dut_hs++;
  end

  bit rdy_mode = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    int start;
    int t;
    start = m_acc; t = 0;
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    while (m_acc == start && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (m_acc == start) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before 5ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_hs;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, busy, carry, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(16'hFFFF, 16'h0001, 1'b0);
    wait_valid(n);
    chk("wrap_latency", n, 4);
    chk("wrap_result", {carry, sum}, {1'b1, 16'h0000});
    take();
    chk("idle_after_take", {in_ready, out_valid}, 2'b10);

    issue(16'h1234, 16'h4321, 1'b1);
    chk("run_flags", {in_ready, busy}, 2'b01);
    wait_valid(n);
    chk("basic_result", {carry, sum}, {1'b0, 16'h5556});

    a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("stall_hold", {in_ready, out_valid, busy, carry, sum}, {1'b0, 1'b1, 1'b1, 1'b0, 16'h5556});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("not_taken_at_handshake", {in_ready, out_valid, busy}, 3'b100);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("taken_next_cycle", {in_ready, busy}, 2'b01);
    wait_valid(n);
    chk("second_result", {carry, sum}, {1'b0, 16'h0303});
    take();

    issue(16'hABCD, 16'h1111, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("async_reset", {in_ready, out_valid, busy, carry, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("no_spurious_valid", {out_valid, busy}, 2'b00);
    issue(16'h0F0F, 16'hF0F0, 1'b1);
    wait_valid(n);
    chk("post_reset_result", {carry, sum}, {1'b1, 16'h0000});
    take();

    base_hs = dut_hs;
    rdy_mode = 1'b1;
    for (int i = 0; i < 500; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((m_done || m_run != 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    chk("random_result_count", dut_hs - base_hs, 500);

    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk("w4_run", {busy4, ov4, ir4}, 3'b100);
    @(posedge clk); #1;
    chk("w4_result", {ov4, carry4, sum4}, {1'b1, 1'b1, 4'hF});
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
    chk("w4_taken", {ov4, ir4}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
